// File: rtl/trap_sequencer.sv
// trap_sequencer
// Drives the CSR file's single write port when a trap is taken or an MRET
// retires, then issues a one-cycle fetch redirect. Every output is registered:
// the combinational block works out what the outputs should be in the next
// state, and one clock edge loads the state and the outputs together.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   exc_valid           trap request pulse (exc_pc/exc_cause/exc_tval qualify it)
//   mret_valid          MRET retire pulse
//   mstatus_rd          live mstatus read from the CSR file
//   trap_vec            live mtvec read from the CSR file
//   exception_pc        live mepc read from the CSR file
//   wb_csr/write_addr/in_data   CSR write port
//   busy                pipeline stall, high for the whole sequence
//   redirect_valid/redirect_pc  fetch redirect strobe and target
module trap_sequencer #(
   parameter logic [11:0] ADDR_MSTATUS = 12'h300,
   parameter logic [11:0] ADDR_MEPC    = 12'h341,
   parameter logic [11:0] ADDR_MCAUSE  = 12'h342,
   parameter logic [11:0] ADDR_MTVAL   = 12'h343,
   parameter bit          VECTORED_EN  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_cause,
   input  logic [31:0] exc_tval,
   input  logic        mret_valid,
   input  logic [31:0] mstatus_rd,
   input  logic [31:0] trap_vec,
   input  logic [31:0] exception_pc,
   output logic        wb_csr,
   output logic [11:0] write_addr,
   output logic [31:0] in_data,
   output logic        busy,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   typedef enum logic [2:0] {
      IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_REDIR, M_STATUS, M_REDIR
   } state_t;

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   state_t      state, state_nx;
   logic [31:0] cause_p1, tval_p1;

   logic        wb_nx, busy_nx, rv_nx;
   logic [11:0] addr_nx;
   logic [31:0] data_nx, rpc_nx;

   // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode.
   function automatic logic [31:0] trap_status(input logic [31:0] m);
      logic [31:0] r;
      r        = m;
      r[7]     = m[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // MRET: MIE <= MPIE, MPIE <= 1, MPP stays M-mode (only mode implemented).
   function automatic logic [31:0] mret_status(input logic [31:0] m);
      logic [31:0] r;
      r        = m;
      r[3]     = m[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // Vectored mode only applies to interrupts; MODE 2/3 fall back to direct.
   // The shift drops cause bits 31:30, giving base + cause[30:0]*4 mod 2^32.
   function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                               input logic [31:0] cause);
      logic [31:0] base;
      base = tvec & WORD_MASK;
      if (VECTORED_EN && tvec[1:0] == 2'b01 && cause[31])
         return base + (cause << 2);
      return base;
   endfunction

   always_comb begin
      state_nx = state;
      wb_nx    = 1'b0;
      addr_nx  = '0;
      data_nx  = '0;
      busy_nx  = 1'b0;
      rv_nx    = 1'b0;
      rpc_nx   = '0;
      case (state)
         IDLE: begin
            // Exception has priority; a simultaneous MRET is dropped.
            if (exc_valid) begin
               state_nx = T_EPC;
               wb_nx    = 1'b1;
               addr_nx  = ADDR_MEPC;
               data_nx  = exc_pc & WORD_MASK;
               busy_nx  = 1'b1;
            end else if (mret_valid) begin
               state_nx = M_STATUS;
               wb_nx    = 1'b1;
               addr_nx  = ADDR_MSTATUS;
               data_nx  = mret_status(mstatus_rd);
               busy_nx  = 1'b1;
            end
         end
         T_EPC: begin
            state_nx = T_CAUSE;
            wb_nx    = 1'b1;
            addr_nx  = ADDR_MCAUSE;
            data_nx  = cause_p1;
            busy_nx  = 1'b1;
         end
         T_CAUSE: begin
            state_nx = T_TVAL;
            wb_nx    = 1'b1;
            addr_nx  = ADDR_MTVAL;
            data_nx  = tval_p1;
            busy_nx  = 1'b1;
         end
         T_TVAL: begin
            state_nx = T_STATUS;
            wb_nx    = 1'b1;
            addr_nx  = ADDR_MSTATUS;
            data_nx  = trap_status(mstatus_rd);
            busy_nx  = 1'b1;
         end
         T_STATUS: begin
            state_nx = T_REDIR;
            rv_nx    = 1'b1;
            rpc_nx   = trap_target(trap_vec, cause_p1);
            busy_nx  = 1'b1;
         end
         M_STATUS: begin
            state_nx = M_REDIR;
            rv_nx    = 1'b1;
            rpc_nx   = exception_pc & WORD_MASK;
            busy_nx  = 1'b1;
         end
         T_REDIR, M_REDIR: state_nx = IDLE;
         default:          state_nx = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         wb_csr         <= 1'b0;
         write_addr     <= '0;
         in_data        <= '0;
         busy           <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         state          <= state_nx;
         wb_csr         <= wb_nx;
         write_addr     <= addr_nx;
         in_data        <= data_nx;
         busy           <= busy_nx;
         redirect_valid <= rv_nx;
         redirect_pc    <= rpc_nx;
      end
   end

   // Captured trap payload (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (state == IDLE && exc_valid) begin
         cause_p1 <= exc_cause;
         tval_p1  <= exc_tval;
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc_valid, mret_valid;
   logic [31:0] exc_pc, exc_cause, exc_tval;
   logic [31:0] mstatus_rd, trap_vec, exception_pc;

   logic        wb_csr, busy, redirect_valid;
   logic [11:0] write_addr;
   logic [31:0] in_data, redirect_pc;
   logic        wb_csr_d, busy_d, redirect_valid_d;
   logic [11:0] write_addr_d;
   logic [31:0] in_data_d, redirect_pc_d;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   trap_sequencer #(.VECTORED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_pc(exc_pc),
      .exc_cause(exc_cause), .exc_tval(exc_tval), .mret_valid(mret_valid),
      .mstatus_rd(mstatus_rd), .trap_vec(trap_vec), .exception_pc(exception_pc),
      .wb_csr(wb_csr), .write_addr(write_addr), .in_data(in_data), .busy(busy),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

   trap_sequencer #(.VECTORED_EN(1'b0)) dut_d (
      .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_pc(exc_pc),
      .exc_cause(exc_cause), .exc_tval(exc_tval), .mret_valid(mret_valid),
      .mstatus_rd(mstatus_rd), .trap_vec(trap_vec), .exception_pc(exception_pc),
      .wb_csr(wb_csr_d), .write_addr(write_addr_d), .in_data(in_data_d), .busy(busy_d),
      .redirect_valid(redirect_valid_d), .redirect_pc(redirect_pc_d));

   // Observation vector: {wb, addr, data, busy, redirect_valid, redirect_pc}
   function automatic logic [78:0] pack(input logic wb, input logic [11:0] a,
                                        input logic [31:0] d, input logic b,
                                        input logic rv, input logic [31:0] rpc);
      return {wb, a, d, b, rv, rpc};
   endfunction

   localparam logic [78:0] QUIET = 79'd0;

   function automatic logic [31:0] m_trap_status(input logic [31:0] m);
      return (m & ~32'h0000_1888) | 32'h0000_1800 | (((m >> 3) & 32'd1) << 7);
   endfunction

   function automatic logic [31:0] m_mret_status(input logic [31:0] m);
      return (m & ~32'h0000_1888) | 32'h0000_1880 | (((m >> 7) & 32'd1) << 3);
   endfunction

   function automatic logic [31:0] m_target(input logic [31:0] tvec,
                                            input logic [31:0] cause, input bit vec);
      logic [31:0] base;
      base = tvec - (tvec % 4);
      if (vec && (tvec % 4) == 1 && cause >= 32'h8000_0000)
         return base + (cause - 32'h8000_0000) * 4;
      return base;
   endfunction

   // Expected outputs in cycle k (1..5) after a trap is accepted.
   function automatic logic [78:0] trap_exp(input int k, input logic [31:0] pc,
         input logic [31:0] cause, input logic [31:0] tval, input logic [31:0] mst,
         input logic [31:0] tvec, input bit vec);
      case (k)
         1:       return pack(1'b1, 12'h341, pc - (pc % 4), 1'b1, 1'b0, 32'd0);
         2:       return pack(1'b1, 12'h342, cause, 1'b1, 1'b0, 32'd0);
         3:       return pack(1'b1, 12'h343, tval, 1'b1, 1'b0, 32'd0);
         4:       return pack(1'b1, 12'h300, m_trap_status(mst), 1'b1, 1'b0, 32'd0);
         default: return pack(1'b0, 12'h000, 32'd0, 1'b1, 1'b1, m_target(tvec, cause, vec));
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [78:0] exp_v, input logic [78:0] exp_d);
      logic [78:0] obs_v, obs_d;
      obs_v = {wb_csr, write_addr, in_data, busy, redirect_valid, redirect_pc};
      obs_d = {wb_csr_d, write_addr_d, in_data_d, busy_d, redirect_valid_d, redirect_pc_d};
      tests++;
      assert (obs_v === exp_v) else begin
         fails++;
         $error("FAIL %s vec: got %h expected %h", tag, obs_v, exp_v);
      end
      tests++;
      assert (obs_d === exp_d) else begin
         fails++;
         $error("FAIL %s direct: got %h expected %h", tag, obs_d, exp_d);
      end
   endtask

   // Runs a full trap from accept to the first IDLE cycle. mret_at (1..5)
   // raises an MRET pulse during that cycle; with_mret pulses MRET on accept.
   task automatic run_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval, input int mret_at, input bit with_mret);
      exc_valid = 1'b1; exc_pc = pc; exc_cause = cause; exc_tval = tval;
      mret_valid = with_mret;
      tick();
      exc_valid = 1'b0; mret_valid = 1'b0;
      exc_pc = $urandom; exc_cause = $urandom; exc_tval = $urandom;
      for (int k = 1; k <= 5; k++) begin
         check(tag, trap_exp(k, pc, cause, tval, mstatus_rd, trap_vec, 1'b1),
                    trap_exp(k, pc, cause, tval, mstatus_rd, trap_vec, 1'b0));
         mret_valid = (k == mret_at);
         tick();
      end
      mret_valid = 1'b0;
      check({tag, "_idle"}, QUIET, QUIET);
   endtask

   task automatic run_mret(input string tag);
      logic [78:0] e;
      mret_valid = 1'b1;
      tick();
      mret_valid = 1'b0;
      e = pack(1'b1, 12'h300, m_mret_status(mstatus_rd), 1'b1, 1'b0, 32'd0);
      check({tag, "_w"}, e, e);
      tick();
      e = pack(1'b0, 12'h000, 32'd0, 1'b1, 1'b1, exception_pc - (exception_pc % 4));
      check({tag, "_r"}, e, e);
      tick();
      check({tag, "_idle"}, QUIET, QUIET);
   endtask

   initial begin
      logic [31:0] pc, cause, tval;
      rst = 1'b1; exc_valid = 1'b0; mret_valid = 1'b0;
      exc_pc = '0; exc_cause = '0; exc_tval = '0;
      mstatus_rd = 32'h0000_0008; trap_vec = 32'h0000_0200; exception_pc = '0;
      tick();
      tick();
      check("reset", QUIET, QUIET);
      rst = 1'b0;
      tick();
      check("idle", QUIET, QUIET);

      // Directed trap
      run_trap("trap_basic", 32'h0000_0104, 32'h0000_0002, 32'hDEAD_BEEF, 0, 1'b0);

      // Vectored interrupt (direct instance sees plain base)
      trap_vec = 32'h0000_0301;
      run_trap("trap_vect", 32'h0000_1000, 32'h8000_0007, 32'h0, 0, 1'b0);
      // MODE 2'b11 is direct even for interrupts
      trap_vec = 32'h0000_0303;
      run_trap("trap_mode3", 32'h0000_2002, 32'h8000_0003, 32'h1234, 0, 1'b0);
      trap_vec = 32'h0000_0200;

      // MRET
      mstatus_rd = 32'h0000_1880; exception_pc = 32'h0000_0106;
      run_mret("mret");

      // Simultaneous request, then MRET pulse mid-trap
      mstatus_rd = 32'h0000_0008;
      run_trap("trap_both", 32'h0000_0400, 32'h0000_0005, 32'h55, 0, 1'b1);
      run_trap("trap_mret_mid", 32'h0000_0500, 32'h0000_0006, 32'h66, 3, 1'b0);

      // Reset in cycle 2 of a trap
      exc_valid = 1'b1; exc_pc = 32'h0000_0800; exc_cause = 32'h0000_000B; exc_tval = 32'h77;
      tick();
      exc_valid = 1'b0;
      check("rst_c1", trap_exp(1, 32'h800, 32'hB, 32'h77, mstatus_rd, trap_vec, 1'b1),
                      trap_exp(1, 32'h800, 32'hB, 32'h77, mstatus_rd, trap_vec, 1'b0));
      tick();
      check("rst_c2", trap_exp(2, 32'h800, 32'hB, 32'h77, mstatus_rd, trap_vec, 1'b1),
                      trap_exp(2, 32'h800, 32'hB, 32'h77, mstatus_rd, trap_vec, 1'b0));
      rst = 1'b1;
      tick();
      check("rst_abort", QUIET, QUIET);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_quiet", QUIET, QUIET);
      end
      run_trap("trap_after_rst", 32'h0000_0900, 32'h0000_0001, 32'h88, 0, 1'b0);

      // Random back-to-back traps; each new pulse lands in the first IDLE cycle
      for (int i = 0; i < 24; i++) begin
         pc = $urandom;
         tval = $urandom;
         if ($urandom_range(0, 1) == 1)
            cause = 32'h8000_0000 | $urandom_range(0, 63);
         else
            cause = $urandom;
         trap_vec = ($urandom & 32'hFFFF_FFFC) | $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) trap_vec[1:0] = 2'b01;
         mstatus_rd = $urandom;
         run_trap("trap_rand", pc, cause, tval, $urandom_range(0, 5), 1'(($urandom_range(0, 3) == 0)));
         if ($urandom_range(0, 3) == 0) begin
            exception_pc = $urandom;
            run_mret("mret_rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
